gmii_rx: RTL and testbench

GMII_RX -- requirements
Module: gmii_rx

---
 rtl/gmii_rx_pkg.sv | 39 +++
 rtl/crc32_d8.sv | 24 ++
 rtl/gmii_rx.sv | 171 +++++++++++++++++
 tb/tb_gmii_rx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_rx_pkg.sv
// Shared constants for the GMII receive path: FSM encodings, CRC-32 parameters,
// preamble/SFD bytes, frame_err bit positions and the byte-wise CRC step.
package gmii_rx_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PREAMBLE = 2'd1;
    localparam logic [1:0] ST_DATA     = 2'd2;
    localparam logic [1:0] ST_DROP     = 2'd3;

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    localparam int ERR_PHY = 2;
    localparam int ERR_LEN = 1;
    localparam int ERR_CRC = 0;

    // Reflected CRC-32, one byte per call, data consumed LSB first.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// 8-bit parallel IEEE 802.3 CRC-32 register with synchronous clear (to the
// init value) and byte enable; clear wins over enable.
module crc32_d8
    import gmii_rx_pkg::*;
(
    input  logic        clk_125m,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (clr) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc32_next(crc, data);
        end
    end

endmodule

// File: rtl/gmii_rx.sv
// GMII receiver: preamble/SFD detection, FCS stripping through a 4-byte delay
// line, CRC/length/PHY error checks and a one-cycle end-of-frame status strobe.
module gmii_rx
    import gmii_rx_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk_125m,
    input  logic        rst_n,
    input  logic [7:0]  rxd,
    input  logic        rx_dv,
    input  logic        rx_er,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        frame_done,
    output logic        frame_good,
    output logic [2:0]  frame_err,
    output logic [10:0] frame_len
);

    localparam logic [10:0] MIN_CNT   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_CNT   = 11'(MAX_LEN);
    localparam logic [10:0] OVF_CNT   = 11'(MAX_LEN + 1);
    localparam logic [10:0] FCS_BYTES = 11'd4;

    logic [7:0]       rxd_q;
    logic             dv_q, er_q, dv_prev;
    logic [1:0]       state, state_nx;
    logic             in_frame, phy_flag;
    logic [10:0]      byte_cnt, cnt_inc;
    logic [3:0][7:0]  delay_line;
    logic [31:0]      crc_val;
    logic             take, fwd, crc_clr, end_frame;
    logic [2:0]       err_vec;
    logic [10:0]      len_val;

    // NOTE: dv resets high so a frame already on the wire at reset release
    // never looks like a fresh rising edge; only a real low-to-high counts.
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            rxd_q   <= '0;
            dv_q    <= 1'b1;
            er_q    <= 1'b0;
            dv_prev <= 1'b1;
        end else begin
            rxd_q   <= rxd;
            dv_q    <= rx_dv;
            er_q    <= rx_er;
            dv_prev <= dv_q;
        end
    end

    assign cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nx  = state;
        take      = 1'b0;
        crc_clr   = 1'b0;
        end_frame = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dv_q && !dv_prev) begin
                    state_nx = (rxd_q == PRE_BYTE) ? ST_PREAMBLE : ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!dv_q) begin
                    state_nx = ST_IDLE;
                end else if (er_q) begin
                    state_nx = ST_DROP;
                end else if (rxd_q == SFD_BYTE) begin
                    state_nx = ST_DATA;
                    crc_clr  = 1'b1;
                end else if (rxd_q != PRE_BYTE) begin
                    state_nx = ST_DROP;
                end
            end
            ST_DATA: begin
                if (!dv_q) begin
                    state_nx  = ST_IDLE;
                    end_frame = 1'b1;
                end else if (er_q) begin
                    state_nx = ST_DROP;
                end else begin
                    take = 1'b1;
                    if (cnt_inc == OVF_CNT) state_nx = ST_DROP;
                end
            end
            default: begin
                if (!dv_q) begin
                    state_nx  = ST_IDLE;
                    end_frame = in_frame;
                end
            end
        endcase
    end

    // A byte leaves the delay line only once four newer bytes have arrived,
    // which keeps the trailing FCS off rx_data.
    assign fwd = take && (cnt_inc != OVF_CNT) && (byte_cnt >= FCS_BYTES);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            in_frame   <= 1'b0;
            phy_flag   <= 1'b0;
            byte_cnt   <= '0;
            delay_line <= '0;
        end else begin
            state <= state_nx;
            if (crc_clr) begin
                in_frame <= 1'b1;
                phy_flag <= 1'b0;
                byte_cnt <= '0;
            end else begin
                if (state == ST_IDLE || state == ST_PREAMBLE) in_frame <= 1'b0;
                if ((state == ST_DATA || state == ST_DROP) && er_q) phy_flag <= 1'b1;
                if (take) byte_cnt <= cnt_inc;
            end
            if (take) delay_line <= {delay_line[2:0], rxd_q};
        end
    end

    crc32_d8 u_crc (
        .clk_125m (clk_125m),
        .rst_n    (rst_n),
        .clr      (crc_clr),
        .en       (take),
        .data     (rxd_q),
        .crc      (crc_val)
    );

    // The residue constant is quoted in normal bit order; the register is reflected.
    always_comb begin
        err_vec          = '0;
        err_vec[ERR_PHY] = phy_flag | er_q;
        err_vec[ERR_LEN] = (byte_cnt < MIN_CNT) || (byte_cnt > MAX_CNT);
        err_vec[ERR_CRC] = (bit_reverse32(crc_val) != CRC_RESIDUE);
    end

    assign len_val = (byte_cnt >= FCS_BYTES) ? (byte_cnt - FCS_BYTES) : 11'd0;

    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_sof     <= 1'b0;
            frame_done <= 1'b0;
            frame_good <= 1'b0;
            frame_err  <= '0;
            frame_len  <= '0;
        end else begin
            rx_valid   <= fwd;
            rx_sof     <= fwd && (byte_cnt == FCS_BYTES);
            frame_done <= end_frame;
            if (fwd) rx_data <= delay_line[3];
            if (end_frame) begin
                frame_err  <= err_vec;
                frame_good <= (err_vec == 3'b000);
                frame_len  <= len_val;
            end
        end
    end

endmodule

// File: tb/tb_gmii_rx.sv
// Directed bench for gmii_rx: a table of frame shapes with hand-derived
// results, plus sequences for back-to-back frames, dv/er collision and reset.
module tb_gmii_rx;

    logic        clk_125m = 1'b0;
    logic        rst_n;
    logic [7:0]  rxd;
    logic        rx_dv, rx_er;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, frame_done, frame_good;
    logic [2:0]  frame_err;
    logic [10:0] frame_len;

    always #4 clk_125m = ~clk_125m;

    gmii_rx #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk_125m   (clk_125m),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .rx_dv      (rx_dv),
        .rx_er      (rx_er),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_sof     (rx_sof),
        .frame_done (frame_done),
        .frame_good (frame_good),
        .frame_err  (frame_err),
        .frame_len  (frame_len)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    int          nv, sof_cnt, sof_bad, data_bad, done_cnt;
    logic [2:0]  last_err;
    logic        last_good;
    logic [10:0] last_len;
    bit          mon_clr = 1'b0;

    always @(negedge clk_125m) begin
        if (mon_clr) begin
            nv = 0; sof_cnt = 0; sof_bad = 0; data_bad = 0; done_cnt = 0;
            last_err = 'x; last_good = 'x; last_len = 'x;
        end else begin
            if (rx_sof) sof_cnt++;
            if (rx_sof && !(rx_valid && nv == 0)) sof_bad++;
            if (rx_valid) begin
                if (rx_data !== 8'(nv)) data_bad++;
                nv++;
            end
            if (frame_done) begin
                done_cnt++;
                last_err  = frame_err;
                last_good = frame_good;
                last_len  = frame_len;
            end
        end
    end

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk_125m);
        #1 mon_clr = 1'b0;
    endtask

    task automatic drive(input logic [7:0] d, input logic dv, input logic er);
        @(posedge clk_125m);
        #1;
        rxd = d; rx_dv = dv; rx_er = er;
    endtask

    logic [7:0] fb[$];
    bit         fe[$];

    // pre_kind: 0 normal, 1 corrupted 0x13, 2 bad first byte, 3 rx_er in preamble.
    task automatic build(input int plen, input int pre_kind, input int er_at, input logic [7:0] fcs_x);
        logic [31:0] c;
        logic [7:0]  b;
        fb.delete(); fe.delete();
        for (int k = 0; k < 7; k++) begin
            b = 8'h55;
            if (pre_kind == 1 && k == 2) b = 8'h13;
            if (pre_kind == 2 && k == 0) b = 8'hAA;
            fb.push_back(b);
            fe.push_back(pre_kind == 3 && k == 2);
        end
        fb.push_back(8'hD5); fe.push_back(1'b0);
        c = 32'hFFFF_FFFF;
        for (int j = 0; j < plen; j++) begin
            b = 8'(j);
            fb.push_back(b); fe.push_back(j == er_at);
            c = c ^ {24'h0, b};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        fb.push_back(c[7:0]);   fe.push_back(1'b0);
        fb.push_back(c[15:8]);  fe.push_back(1'b0);
        fb.push_back(c[23:16]); fe.push_back(1'b0);
        fb.push_back(c[31:24] ^ fcs_x); fe.push_back(1'b0);
    endtask

    task automatic send(input int gap);
        for (int i = 0; i < fb.size(); i++) drive(fb[i], 1'b1, fe[i]);
        repeat (gap) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " rx_data"},    rx_data,    0);
        check({tag, " rx_valid"},   rx_valid,   0);
        check({tag, " rx_sof"},     rx_sof,     0);
        check({tag, " frame_done"}, frame_done, 0);
        check({tag, " frame_good"}, frame_good, 0);
        check({tag, " frame_err"},  frame_err,  0);
        check({tag, " frame_len"},  frame_len,  0);
    endtask

    task automatic check_good60(input string tag);
        check({tag, " nvalid"},  nv, 60);
        check({tag, " sof"},     sof_cnt, 1);
        check({tag, " data"},    data_bad, 0);
        check({tag, " done"},    done_cnt, 1);
        check({tag, " err"},     last_err, 3'b000);
        check({tag, " good"},    last_good, 1);
        check({tag, " len"},     last_len, 60);
    endtask

    typedef struct {
        string      name;
        int         plen;
        int         pre_kind;
        int         er_at;
        logic [7:0] fcs_x;
        int         exp_nv;
        bit         exp_done;
        logic [2:0] exp_err;
        logic [2:0] err_mask;
        int         exp_len;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int nv_snap, done_snap;

    initial begin
        vecs[0]  = '{"good60",   60,   0, -1, 8'h00, 60,   1'b1, 3'b000, 3'b111, 60};
        vecs[1]  = '{"badfcs",   60,   0, -1, 8'h01, 60,   1'b1, 3'b001, 3'b111, 60};
        vecs[2]  = '{"er10",     60,   0, 10, 8'h00, 6,    1'b1, 3'b100, 3'b100, 6};
        vecs[3]  = '{"runt20",   20,   0, -1, 8'h00, 20,   1'b1, 3'b010, 3'b111, 20};
        vecs[4]  = '{"fcsonly",  0,    0, -1, 8'h00, 0,    1'b1, 3'b010, 3'b111, 0};
        vecs[5]  = '{"pay1",     1,    0, -1, 8'h00, 1,    1'b1, 3'b010, 3'b111, 1};
        vecs[6]  = '{"min-1",    59,   0, -1, 8'h00, 59,   1'b1, 3'b010, 3'b111, 59};
        vecs[7]  = '{"max",      1514, 0, -1, 8'h00, 1514, 1'b1, 3'b000, 3'b111, 1514};
        vecs[8]  = '{"max+1",    1515, 0, -1, 8'h00, 1514, 1'b1, 3'b010, 3'b111, 1515};
        vecs[9]  = '{"over1600", 1596, 0, -1, 8'h00, 1514, 1'b1, 3'b010, 3'b010, 1515};
        vecs[10] = '{"pre13",    60,   1, -1, 8'h00, 0,    1'b0, 3'b000, 3'b000, 0};
        vecs[11] = '{"preAA",    60,   2, -1, 8'h00, 0,    1'b0, 3'b000, 3'b000, 0};
        vecs[12] = '{"preEr",    60,   3, -1, 8'h00, 0,    1'b0, 3'b000, 3'b000, 0};

        rst_n = 1'b0; rxd = 8'h00; rx_dv = 1'b0; rx_er = 1'b0;
        repeat (3) @(posedge clk_125m);
        #1 check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (3) drive(8'h00, 1'b0, 1'b0);

        for (int v = 0; v < 13; v++) begin
            clear_mon();
            build(vecs[v].plen, vecs[v].pre_kind, vecs[v].er_at, vecs[v].fcs_x);
            send(8);
            check({vecs[v].name, " nvalid"}, nv, vecs[v].exp_nv);
            check({vecs[v].name, " sof"}, sof_cnt, (vecs[v].exp_nv > 0) ? 1 : 0);
            check({vecs[v].name, " sofpos"}, sof_bad, 0);
            check({vecs[v].name, " data"}, data_bad, 0);
            check({vecs[v].name, " done"}, done_cnt, vecs[v].exp_done);
            if (vecs[v].exp_done) begin
                check({vecs[v].name, " err"}, last_err & vecs[v].err_mask, vecs[v].exp_err);
                check({vecs[v].name, " good"}, last_good, vecs[v].exp_err == 3'b000);
                check({vecs[v].name, " len"}, last_len, vecs[v].exp_len);
            end
        end

        // Corrupted preamble, one idle cycle, then a good frame.
        clear_mon();
        build(60, 1, -1, 8'h00);
        send(1);
        build(60, 0, -1, 8'h00);
        send(8);
        check_good60("gap1");

        // Reset pulse in the middle of the payload.
        clear_mon();
        build(60, 0, -1, 8'h00);
        for (int i = 0; i < fb.size(); i++) begin
            drive(fb[i], 1'b1, 1'b0);
            if (i == 38) #1 rst_n = 1'b0;
            if (i == 40) #1 check_outputs_zero("midrst");
            if (i == 41) begin
                #1 rst_n = 1'b1;
                nv_snap   = nv;
                done_snap = done_cnt;
            end
        end
        repeat (8) drive(8'h00, 1'b0, 1'b0);
        check("midrst tail nvalid", nv, nv_snap);
        check("midrst tail done", done_cnt, done_snap);
        clear_mon();
        build(60, 0, -1, 8'h00);
        send(8);
        check_good60("afterrst");

        // rx_dv falls in the same cycle rx_er rises.
        clear_mon();
        build(60, 0, -1, 8'h00);
        for (int i = 0; i < fb.size(); i++) drive(fb[i], 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b1);
        repeat (8) drive(8'h00, 1'b0, 1'b0);
        check("dvfall_er nvalid", nv, 60);
        check("dvfall_er done", done_cnt, 1);
        check("dvfall_er err", last_err, 3'b100);
        check("dvfall_er good", last_good, 0);
        check("dvfall_er len", last_len, 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
